// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment digit scanner:
// FSM state encoding and anode drive-level helpers.
package sseg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Pin level that switches a digit on / off for the given polarity.
    function automatic logic anode_on(input logic act_low);
        return !act_low;
    endfunction

    function automatic logic anode_off(input logic act_low);
        return act_low;
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Digit slot timer: counts 0..REFRESH_DIV-1, then wraps.
// Ports: clk, rst (async high), clr (hold at 0),
//        blank_done (last dead-time cycle), slot_done (last slot cycle).
module sseg_slot_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic blank_done,
    output logic slot_done
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || slot_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blank_done = (cnt == CW'(BLANK_CYCLES - 1));
    assign slot_done  = (cnt == CW'(REFRESH_DIV - 1));

endmodule

// File: rtl/sseg_digit_scanner.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// Ports: Clk, Reset (async high), En, Load, Value, DPIn, LZSupp in;
//        Hex, DP, Anode, FrameStart, Pending out (all registered).
module sseg_digit_scanner
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    En,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic [NUM_DIGITS-1:0]   DPIn,
    input  logic                    LZSupp,
    output logic [3:0]              Hex,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    FrameStart,
    output logic                    Pending
);

    localparam int   N  = NUM_DIGITS;
    localparam int   IW = $clog2(N);
    localparam logic AL = (ANODE_ACTIVE_LOW != 0);

    localparam logic [N-1:0] A_OFF = {N{anode_off(AL)}};

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [4*N-1:0] shadow_val, disp_val, cval;
    logic [N-1:0]   shadow_dp, disp_dp, cdp;
    logic [N-1:0]   supp;
    logic [N-1:0]   a_on;
    logic [3:0]     nxt_nib;
    logic           nxt_dp;
    logic           zero_above;
    logic           blank_done, slot_done;
    logic           last, enter_f0, nxt_blank, nxt_show, tmr_clr;

    sseg_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (Clk),
        .rst       (Reset),
        .clr       (tmr_clr),
        .blank_done(blank_done),
        .slot_done (slot_done)
    );

    assign last      = (idx == IW'(N - 1));
    assign enter_f0  = En && ((state == ST_IDLE) ||
                       (state == ST_SHOW && slot_done && last));
    assign nxt_blank = En && state == ST_SHOW && slot_done && !last;
    assign nxt_show  = En && state == ST_BLANK && blank_done;
    assign tmr_clr   = !En || (state == ST_IDLE);
    assign nidx      = idx + 1'b1;

    // A Load on the commit edge bypasses the shadow.
    assign cval = Load ? Value : shadow_val;
    assign cdp  = Load ? DPIn  : shadow_dp;

    always_comb begin
        nxt_nib = disp_val[3:0];
        nxt_dp  = disp_dp[0];
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == nidx) begin
                nxt_nib = disp_val[4*i +: 4];
                nxt_dp  = disp_dp[i];
            end
        end
    end

    // Digit i is dark when it and every digit above it are zero with no DP.
    always_comb begin
        supp       = '0;
        zero_above = LZSupp;
        for (int i = N - 1; i >= 1; i--) begin
            zero_above = zero_above &&
                         (disp_val[4*i +: 4] == 4'h0) && !disp_dp[i];
            supp[i]    = zero_above;
        end
    end

    always_comb begin
        a_on = A_OFF;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == idx && !supp[i]) begin
                a_on[i] = anode_on(AL);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            Pending    <= 1'b0;
            Hex        <= 4'h0;
            DP         <= 1'b0;
            FrameStart <= 1'b0;
            Anode      <= A_OFF;
        end else begin
            FrameStart <= enter_f0;
            if (Load) begin
                shadow_val <= Value;
                shadow_dp  <= DPIn;
            end
            if (enter_f0) begin
                disp_val <= cval;
                disp_dp  <= cdp;
                Pending  <= 1'b0;
            end else if (Load) begin
                Pending <= 1'b1;
            end
            if (!En) begin
                state <= ST_IDLE;
                idx   <= '0;
                Anode <= A_OFF;
            end else begin
                unique case (1'b1)
                    enter_f0: begin
                        state <= ST_BLANK;
                        idx   <= '0;
                        Hex   <= cval[3:0];
                        DP    <= cdp[0];
                        Anode <= A_OFF;
                    end
                    nxt_blank: begin
                        state <= ST_BLANK;
                        idx   <= nidx;
                        Hex   <= nxt_nib;
                        DP    <= nxt_dp;
                        Anode <= A_OFF;
                    end
                    nxt_show: begin
                        state <= ST_SHOW;
                        Anode <= a_on;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner (4 digits, 8-cycle slots,
// 2 dead cycles, active-low anodes).
module tb_sseg_digit_scanner;

    logic        Clk = 1'b0;
    logic        Reset, En, Load, LZSupp;
    logic [15:0] Value;
    logic [3:0]  DPIn;
    logic [3:0]  Hex;
    logic        DP;
    logic [3:0]  Anode;
    logic        FrameStart, Pending;

    int checks = 0;
    int errors = 0;

    sseg_digit_scanner #(
        .NUM_DIGITS      (4),
        .REFRESH_DIV     (8),
        .BLANK_CYCLES    (2),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Load      (Load),
        .Value     (Value),
        .DPIn      (DPIn),
        .LZSupp    (LZSupp),
        .Hex       (Hex),
        .DP        (DP),
        .Anode     (Anode),
        .FrameStart(FrameStart),
        .Pending   (Pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called on the negedge of frame cycle 0. Checks cycles 0..last,
    // optionally pulsing Load at cycle load_at. Returns on negedge last+1.
    // Sample vector is {FrameStart, DP, Hex, Anode}.
    task automatic frame(input string nm, input logic [15:0] v,
                         input logic [3:0] dp, input logic [3:0] msk,
                         input int last, input int load_at,
                         input logic [15:0] lv, input logic [3:0] ldp);
        int d, w;
        logic [3:0] ea;
        logic [9:0] ev;
        for (int p = 0; p <= last; p++) begin
            d  = p / 8;
            w  = p % 8;
            ea = 4'hF;
            if (w >= 2 && msk[d]) ea[d] = 1'b0;
            ev = {(p == 0), dp[d], v[4*d +: 4], ea};
            check($sformatf("%s p%0d", nm, p),
                  {22'd0, FrameStart, DP, Hex, Anode}, {22'd0, ev});
            if (p == 0) check($sformatf("%s pend0", nm), Pending, 0);
            if (load_at >= 0 && p > load_at)
                check($sformatf("%s pend p%0d", nm, p), Pending, 1);
            if (p == load_at) begin
                Load  = 1'b1;
                Value = lv;
                DPIn  = ldp;
            end else begin
                Load = 1'b0;
            end
            @(negedge Clk);
        end
        Load = 1'b0;
    endtask

    initial begin
        Reset  = 1'b1;
        En     = 1'b0;
        Load   = 1'b0;
        LZSupp = 1'b0;
        Value  = 16'h0;
        DPIn   = 4'h0;
        #2;
        check("rst anode", Anode, 4'hF);
        check("rst hex", Hex, 0);
        check("rst dp", DP, 0);
        check("rst fs", FrameStart, 0);
        check("rst pend", Pending, 0);

        @(negedge Clk);
        Reset = 1'b0;
        Load  = 1'b1;
        Value = 16'h1A2F;
        DPIn  = 4'b0100;
        @(negedge Clk);
        check("idle pend", Pending, 1);
        check("idle anode", Anode, 4'hF);
        check("idle fs", FrameStart, 0);
        Load = 1'b0;
        En   = 1'b1;
        @(negedge Clk);

        frame("f1", 16'h1A2F, 4'b0100, 4'hF, 31, 10, 16'h1234, 4'h0);
        frame("f2", 16'h1234, 4'h0, 4'hF, 31, 31, 16'h0005, 4'h0);
        LZSupp = 1'b1;
        frame("f3", 16'h0005, 4'h0, 4'b0001, 31, 20, 16'h0000, 4'h0);
        frame("f4", 16'h0000, 4'h0, 4'b0001, 31, 20, 16'h0005, 4'b0100);
        frame("f5", 16'h0005, 4'b0100, 4'b0111, 31, -1, 16'h0, 4'h0);

        frame("f6", 16'h0005, 4'b0100, 4'b0111, 19, -1, 16'h0, 4'h0);
        check("en anode on", Anode, 4'b1011);
        En = 1'b0;
        @(negedge Clk);
        check("dis anode", Anode, 4'hF);
        check("dis hold", {27'd0, DP, Hex}, {27'd0, 5'h10});
        @(negedge Clk);
        @(negedge Clk);
        check("dis anode2", Anode, 4'hF);
        check("dis fs", FrameStart, 0);
        En = 1'b1;
        @(negedge Clk);
        frame("f7", 16'h0005, 4'b0100, 4'b0111, 3, -1, 16'h0, 4'h0);

        check("pre rst anode", Anode, 4'b1110);
        #2;
        Reset = 1'b1;
        #1;
        check("arst anode", Anode, 4'hF);
        check("arst hex", Hex, 0);
        check("arst pend", Pending, 0);
        En = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("post rst", {22'd0, FrameStart, DP, Hex, Anode},
              {22'd0, 10'b0_0_0000_1111});
        En = 1'b1;
        @(negedge Clk);
        frame("f8", 16'h0000, 4'h0, 4'b0001, 31, -1, 16'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
